fir_decim_buffer: RTL and testbench

FIR_DECIM_BUFFER -- requirements
Module: fir_decim_buffer

---
 rtl/fir_decim_buffer.sv | 180 ++++++++++++++++++
 tb/tb_fir_decim_buffer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_decim_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : fir_decim_buffer
//  Purpose  : Sits behind a 9-tap FIR filter. It discards the filter's
//             warm-up samples, keeps every DECIM-th accepted sample after
//             that, and queues the kept samples in a small output FIFO that
//             drains through a valid/ready handshake.
//  Ports    : clk       - clock, all state changes on the rising edge
//             rstN      - asynchronous active-low reset
//             y         - filter output sample (signed 16 bit)
//             in_valid  - y is valid this cycle (no input backpressure)
//             restart   - synchronous soft restart (empties FIFO, re-warms)
//             out_data  - FIFO head word (0 while empty)
//             out_valid - FIFO non-empty
//             out_ready - consumer accepts the head word
//             level     - FIFO occupancy
//             overflow  - sticky: a kept sample was dropped on a full FIFO
//             clr_ovf   - synchronous clear of overflow (a new drop wins)
//  Revision : 1.0 - initial release
// ============================================================================
module fir_decim_buffer #(
  parameter int DECIM  = 4,   // 1..16
  parameter int WARMUP = 9,   // 0..255
  parameter int DEPTH  = 4    // power of two, 2..16
) (
  input  logic                           clk,
  input  logic                           rstN,
  input  logic signed [15:0]             y,
  input  logic                           in_valid,
  input  logic                           restart,
  output logic signed [15:0]             out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(DEPTH+1)-1:0]     level,
  output logic                           overflow,
  input  logic                           clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = 4;   // wide enough for phase 0..15
  localparam int CW = 8;   // wide enough for warm_cnt 0..254

  // WARMUP-1 wraps to all-ones when WARMUP==0; harmless because WARM is
  // never entered in that configuration.
  localparam logic [CW-1:0] WARM_LAST = CW'(WARMUP - 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(DECIM - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);

  typedef enum logic [0:0] {
    ST_WARM = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t START_STATE = (WARMUP == 0) ? ST_RUN : ST_WARM;

  state_t                  state_q,    state_d;
  logic [CW-1:0]           warm_cnt_q, warm_cnt_d;
  logic [PW-1:0]           phase_q,    phase_d;
  logic [AW-1:0]           wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q,   rd_ptr_d;
  logic [LW-1:0]           level_q,    level_d;
  logic                    overflow_q, overflow_d;
  logic signed [15:0]      mem_q [DEPTH];

  logic                    push_req;
  logic                    do_push;
  logic                    do_pop;
  logic                    ovf_set;
  logic                    full;
  logic                    not_empty;

  assign not_empty = (level_q != '0);
  assign full      = (level_q == FULL_LVL);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    phase_d    = phase_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    push_req   = 1'b0;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    ovf_set    = 1'b0;

    if (restart) begin
      // Restart outranks everything this cycle, including the sample on y
      // and any pop the consumer asks for.
      state_d    = START_STATE;
      warm_cnt_d = '0;
      phase_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
    end else begin
      unique case (state_q)
        ST_WARM: begin
          if (in_valid) begin
            if (warm_cnt_q == WARM_LAST) begin
              state_d    = ST_RUN;
              warm_cnt_d = '0;
              phase_d    = '0;
            end else begin
              warm_cnt_d = warm_cnt_q + CW'(1);
            end
          end
        end
        ST_RUN: begin
          if (in_valid) begin
            push_req = (phase_q == '0);
            phase_d  = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
          end
        end
        default: state_d = START_STATE;
      endcase

      do_pop = not_empty && out_ready;
      // A simultaneous pop frees the slot, so a full FIFO can still accept.
      do_push = push_req && (!full || do_pop);
      ovf_set = push_req && full && !do_pop;

      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);

      if (do_push && !do_pop) begin
        level_d = level_q + LW'(1);
      end else if (!do_push && do_pop) begin
        level_d = level_q - LW'(1);
      end
    end

    // Restart leaves the flag alone; a fresh drop beats a clear.
    overflow_d = ovf_set | (overflow_q & ~clr_ovf);
  end

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= START_STATE;
      warm_cnt_q <= '0;
      phase_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      phase_q    <= phase_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO storage. Not reset: stale words are never visible because the head
  // is masked to zero whenever the FIFO is empty.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= y;
    end
  end

  assign out_data  = not_empty ? mem_q[rd_ptr_q] : '0;
  assign out_valid = not_empty;
  assign level     = level_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_decim_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_decim_buffer
//  Purpose  : Directed self-checking bench for fir_decim_buffer at default
//             parameters (DECIM=4, WARMUP=9, DEPTH=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fir_decim_buffer;

  logic               clk;
  logic               rstN;
  logic signed [15:0] y;
  logic               in_valid;
  logic               restart;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic [2:0]         level;
  logic               overflow;
  logic               clr_ovf;

  int n_cmp;
  int n_bad;

  fir_decim_buffer #(
    .DECIM  (4),
    .WARMUP (9),
    .DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rstN      (rstN),
    .y         (y),
    .in_valid  (in_valid),
    .restart   (restart),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rstN      = 1'b0;
    in_valid  = 1'b0;
    restart   = 1'b0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    y         = '0;
    tick();
    tick();
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0d want 0", out_valid); end
    n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", level); end
    n_cmp++; if (out_data !== 16'sd0) begin n_bad++; $display("FAIL reset_data: got %0d want 0", out_data); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %0d want 0", overflow); end
  endtask

  // Continuous stream, consumer always ready: 9,13,17,... each visible once.
  task automatic test_continuous();
    logic exp_v;
    apply_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i <= 30; i++) begin
      y = 16'(i);
      tick();
      exp_v = (i >= 9) && (((i - 9) % 4) == 0);
      n_cmp++;
      if (out_valid !== exp_v) begin
        n_bad++; $display("FAIL cont_valid[y=%0d]: got %0d want %0d", i, out_valid, exp_v);
      end
      if (exp_v) begin
        n_cmp++;
        if (out_data !== 16'(i)) begin
          n_bad++; $display("FAIL cont_data[y=%0d]: got %0d want %0d", i, out_data, i);
        end
      end
      n_cmp++;
      if (level > 3'd1) begin
        n_bad++; $display("FAIL cont_level[y=%0d]: got %0d want <=1", i, level);
      end
    end
  endtask

  // Fill to full, drop y=25 (with clr_ovf coincident), then drain in order.
  task automatic test_overflow();
    logic signed [15:0] popped [8];
    int npop;
    int exp_pop [5];
    exp_pop = '{9, 13, 17, 21, 29};
    apply_reset();
    in_valid = 1'b1;
    for (int i = 0; i <= 25; i++) begin
      y       = 16'(i);
      clr_ovf = (i == 25);
      tick();
      if (i == 21) begin
        n_cmp++; if (level !== 3'd4) begin n_bad++; $display("FAIL ovf_fill_level: got %0d want 4", level); end
      end
    end
    clr_ovf = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set_wins: got %0d want 1", overflow); end
    n_cmp++; if (level !== 3'd4) begin n_bad++; $display("FAIL ovf_level: got %0d want 4", level); end
    n_cmp++; if (out_data !== 16'sd9) begin n_bad++; $display("FAIL ovf_head: got %0d want 9", out_data); end
    out_ready = 1'b1;
    npop = 0;
    for (int i = 26; i <= 33; i++) begin
      y = 16'(i);
      if (out_valid && npop < 8) begin
        popped[npop] = out_data;
        npop++;
      end
      tick();
    end
    n_cmp++; if (npop !== 5) begin n_bad++; $display("FAIL ovf_pop_count: got %0d want 5", npop); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (k < npop && popped[k] !== 16'(exp_pop[k])) begin
        n_bad++; $display("FAIL ovf_pop[%0d]: got %0d want %0d", k, popped[k], exp_pop[k]);
      end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %0d want 1", overflow); end
    in_valid = 1'b0;
    clr_ovf  = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %0d want 0", overflow); end
  endtask

  // Full FIFO with a pop on the same edge as the push of y=25.
  task automatic test_full_push_pop();
    int exp_d [4];
    exp_d = '{13, 17, 21, 25};
    apply_reset();
    in_valid = 1'b1;
    for (int i = 0; i <= 25; i++) begin
      y         = 16'(i);
      out_ready = (i == 25);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_cmp++; if (level !== 3'd4) begin n_bad++; $display("FAIL fpp_level: got %0d want 4", level); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fpp_ovf: got %0d want 0", overflow); end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (out_data !== 16'(exp_d[k])) begin
        n_bad++; $display("FAIL fpp_drain[%0d]: got %0d want %0d", k, out_data, exp_d[k]);
      end
      tick();
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fpp_empty: got %0d want 0", out_valid); end
  endtask

  // in_valid alternating: only valid samples advance warm-up and phase.
  task automatic test_gapped();
    logic signed [15:0] cap [8];
    int ncap;
    int exp_c [3];
    exp_c = '{18, 26, 34};
    apply_reset();
    out_ready = 1'b1;
    ncap = 0;
    for (int c = 0; c <= 40; c++) begin
      y        = 16'(c);
      in_valid = ((c % 2) == 0);
      tick();
      if (out_valid && ncap < 8) begin
        cap[ncap] = out_data;
        ncap++;
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (ncap !== 3) begin n_bad++; $display("FAIL gap_count: got %0d want 3", ncap); end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (k < ncap && cap[k] !== 16'(exp_c[k])) begin
        n_bad++; $display("FAIL gap_out[%0d]: got %0d want %0d", k, cap[k], exp_c[k]);
      end
    end
  endtask

  // Prefill three words, then flush by reset (use_restart=0) or restart.
  task automatic test_flush(input bit use_restart, input int base);
    logic signed [15:0] cap [8];
    int ncap;
    apply_reset();
    in_valid = 1'b1;
    for (int i = 0; i <= 17; i++) begin
      y = 16'(i);
      tick();
    end
    n_cmp++; if (level !== 3'd3) begin n_bad++; $display("FAIL flush%0d_prefill: got %0d want 3", use_restart, level); end
    if (use_restart) begin
      restart   = 1'b1;
      out_ready = 1'b1;
      y         = 16'sd77;
      tick();
      restart = 1'b0;
    end else begin
      #2;
      rstN = 1'b0;
      #1;
    end
    n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL flush%0d_level: got %0d want 0", use_restart, level); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush%0d_valid: got %0d want 0", use_restart, out_valid); end
    if (!use_restart) begin
      tick();
      rstN = 1'b1;
    end
    out_ready = 1'b1;
    ncap = 0;
    for (int i = 0; i <= 12; i++) begin
      y = 16'(base + i);
      tick();
      if (out_valid && ncap < 8) begin
        cap[ncap] = out_data;
        ncap++;
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (ncap !== 1) begin n_bad++; $display("FAIL flush%0d_count: got %0d want 1", use_restart, ncap); end
    n_cmp++;
    if (ncap >= 1 && cap[0] !== 16'(base + 9)) begin
      n_bad++; $display("FAIL flush%0d_first: got %0d want %0d", use_restart, cap[0], base + 9);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rstN      = 1'b0;
    in_valid  = 1'b0;
    restart   = 1'b0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    y         = '0;
    test_reset();
    test_continuous();
    test_overflow();
    test_full_push_pop();
    test_gapped();
    test_flush(1'b0, 100);
    test_flush(1'b1, 200);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
